// File: rtl/button_debouncer_pkg.sv
// Shared constants for the push-button debouncer: board clock rate and default debounce window.
package button_debouncer_pkg;

    localparam int unsigned CLK_FREQ_HZ             = 100_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

    // Converts a debounce window in milliseconds into clock cycles at CLK_FREQ_HZ.
    function automatic int unsigned ms_to_cycles(input int unsigned ms);
        return (CLK_FREQ_HZ / 1000) * ms;
    endfunction

endpackage

// File: rtl/button_debouncer_debounce_channel.sv
// One button channel: 2-FF synchroniser, stability counter, debounced level and change strobe.
// A new level is accepted after STABLE_CYCLES consecutive mismatching synchronised samples.
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter  int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    localparam int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic db,
    output logic changed
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             chg_q, chg_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            chg_q   <= 1'b0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            chg_q   <= chg_d;
        end
    end

    // Any return to the accepted level restarts the count; counting never accumulates.
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        chg_d = 1'b0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d  = sync2_q;
                cnt_d = '0;
                chg_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign db      = db_q;
    assign changed = chg_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button synchroniser/debouncer; WIDTH independent debounce_channel instances.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned WIDTH         = 4,
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] btn_raw,
    output logic [WIDTH-1:0] btn_db,
    output logic [WIDTH-1:0] btn_changed
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .raw    (btn_raw[i]),
            .db     (btn_db[i]),
            .changed(btn_changed[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: per-cycle vector table for press/bounce/glitch/release, hand sequences for reset and simultaneous updates.
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw, btn_db, btn_changed;
    logic [3:0] raw2, db2, chg2;

    always #5 clk = ~clk;

    button_debouncer #(.WIDTH(4), .STABLE_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_db(btn_db), .btn_changed(btn_changed)
    );

    button_debouncer #(.WIDTH(4), .STABLE_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .btn_raw(raw2), .btn_db(db2), .btn_changed(chg2)
    );

    typedef struct {
        logic [3:0] raw;
        logic [3:0] db;
        logic [3:0] chg;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // n cycles of one raw value; the update lands after segment edge k (k < 0: never).
    task automatic add_seg(input logic [3:0] raw, input int n, input int k,
                           input logic [3:0] db0, input logic [3:0] db1, input logic [3:0] chg);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.raw = raw;
            v.db  = (k >= 0 && i >= k) ? db1 : db0;
            v.chg = (i == k) ? chg : 4'b0000;
            vecs.push_back(v);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic [3:0] r2);
        btn_raw = r;
        raw2    = r2;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 4'b0000;
        raw2    = 4'b0000;

        // clean press ch0
        add_seg(4'b0001, 12, 9, 4'b0000, 4'b0001, 4'b0001);
        // bounce on ch1, then held
        add_seg(4'b0011, 3, -1, 4'b0001, 4'b0001, 4'b0000);
        add_seg(4'b0001, 3, -1, 4'b0001, 4'b0001, 4'b0000);
        add_seg(4'b0011, 3, -1, 4'b0001, 4'b0001, 4'b0000);
        add_seg(4'b0001, 3, -1, 4'b0001, 4'b0001, 4'b0000);
        add_seg(4'b0011, 12, 9, 4'b0001, 4'b0011, 4'b0010);
        // 7-cycle glitch on ch2: one sample short of acceptance
        add_seg(4'b0111, 7, -1, 4'b0011, 4'b0011, 4'b0000);
        add_seg(4'b0011, 10, -1, 4'b0011, 4'b0011, 4'b0000);
        // press then release ch3
        add_seg(4'b1011, 12, 9, 4'b0011, 4'b1011, 4'b1000);
        add_seg(4'b0011, 12, 9, 4'b1011, 4'b0011, 4'b1000);
        // release ch0
        add_seg(4'b0010, 12, 9, 4'b0011, 4'b0010, 4'b0001);

        #12;
        chk("reset db", btn_db, 4'b0000);
        chk("reset changed", btn_changed, 4'b0000);
        chk("reset db2", db2, 4'b0000);
        chk("reset changed2", chg2, 4'b0000);
        reset = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].raw, 4'b0000);
            chk($sformatf("vec%0d db", i), btn_db, vecs[i].db);
            chk($sformatf("vec%0d changed", i), btn_changed, vecs[i].chg);
        end

        // reset asserted between edges while ch0 is mid-count and ch1 is accepted
        for (int k = 0; k < 5; k++) step(4'b0011, 4'b0000);
        chk("midcount db", btn_db, 4'b0010);
        #3;
        reset = 1'b1;
        #1;
        chk("async reset db", btn_db, 4'b0000);
        chk("async reset changed", btn_changed, 4'b0000);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("held reset db %0d", k), btn_db, 4'b0000);
        end
        #3;
        reset = 1'b0;
        for (int k = 0; k < 11; k++) begin
            step(4'b0011, 4'b0000);
            chk($sformatf("post-reset db e%0d", k), btn_db, (k >= 9) ? 4'b0011 : 4'b0000);
            chk($sformatf("post-reset changed e%0d", k), btn_changed, (k == 9) ? 4'b0011 : 4'b0000);
        end

        // all channels together, both window lengths
        #3;
        reset   = 1'b1;
        btn_raw = 4'b0000;
        #10;
        reset = 1'b0;
        for (int k = 0; k < 11; k++) begin
            step(4'b1111, 4'b1111);
            chk($sformatf("simul db e%0d", k), btn_db, (k >= 9) ? 4'b1111 : 4'b0000);
            chk($sformatf("simul changed e%0d", k), btn_changed, (k == 9) ? 4'b1111 : 4'b0000);
            chk($sformatf("simul2 db e%0d", k), db2, (k >= 3) ? 4'b1111 : 4'b0000);
            chk($sformatf("simul2 changed e%0d", k), chg2, (k == 3) ? 4'b1111 : 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
